// File: rtl/instr_fetch_if.sv
// Instruction fetch bus bundle: memory request/response channel
// plus the queue-head handshake toward decode.
interface instr_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, inst_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc,
        output imem_gnt, imem_rvalid, imem_rdata, inst_ready
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: single-outstanding memory requester feeding
// a small FIFO of {pc, instruction} toward decode.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [31:0]          pc_i,
    output logic [31:0]          pc_next_o,
    input  logic                 redirect_i,
    input  logic [31:0]          redirect_pc_i,
    instr_fetch_if.master        bus
);
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [4:0] QD = 5'(QDEPTH);
    localparam logic [PW-1:0] LAST = PW'(QDEPTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    count_q, count_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [31:0]   pend_pc_q, pend_pc_d;
    logic [31:0]   mem_inst_q [QDEPTH];
    logic [31:0]   mem_pc_q   [QDEPTH];

    logic [4:0] occ;
    logic       req;
    logic       fire;
    logic       push;
    logic       pop;
    logic       valid;

    // Outstanding request occupies a slot so a push never lands on a full queue.
    assign occ   = {1'b0, count_q} + {4'b0, state_q != IDLE};
    assign req   = (state_q == IDLE) && !rst_i && !redirect_i && (occ < QD);
    assign fire  = req && bus.imem_gnt;
    assign valid = !rst_i && (count_q != 4'd0);
    assign push  = (state_q == WAIT) && bus.imem_rvalid && !redirect_i;
    assign pop   = valid && bus.inst_ready;

    assign bus.imem_req   = req;
    assign bus.imem_addr  = {pc_i[31:2], 2'b00};
    assign bus.inst_valid = valid;
    assign bus.inst       = rst_i ? 32'h0 : mem_inst_q[rptr_q];
    assign bus.inst_pc    = rst_i ? 32'h0 : mem_pc_q[rptr_q];

    always_comb begin
        pc_next_o = pc_i;
        unique case (1'b1)
            rst_i:      pc_next_o = RESET_PC;
            redirect_i: pc_next_o = redirect_pc_i;
            fire:       pc_next_o = pc_i + 32'd4;
            default:    pc_next_o = pc_i;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pend_pc_d = pend_pc_q;
        case (state_q)
            IDLE: if (fire) begin
                state_d   = WAIT;
                pend_pc_d = pc_i;
            end
            WAIT: begin
                if (bus.imem_rvalid)  state_d = IDLE;
                else if (redirect_i)  state_d = DROP;
            end
            DROP: if (bus.imem_rvalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        if (redirect_i) begin
            count_d = 4'd0;
            rptr_d  = '0;
            wptr_d  = '0;
        end else begin
            if (push) wptr_d = (wptr_q == LAST) ? '0 : wptr_q + 1'b1;
            if (pop)  rptr_d = (rptr_q == LAST) ? '0 : rptr_q + 1'b1;
            if (push && !pop) count_d = count_q + 4'd1;
            if (pop && !push) count_d = count_q - 4'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            count_q   <= 4'd0;
            rptr_q    <= '0;
            wptr_q    <= '0;
            pend_pc_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rptr_q    <= rptr_d;
            wptr_q    <= wptr_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && push) begin
            mem_inst_q[wptr_q] <= bus.imem_rdata;
            mem_pc_q[wptr_q]   <= pend_pc_q;
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: reset, latency, stall, backpressure,
// redirect/drop, PC wrap and mid-request reset.
module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        redir;
    logic [31:0] redir_pc;
    int          total = 0;
    int          bad = 0;

    instr_fetch_if bus ();

    instr_fetch #(
        .RESET_PC (32'h0000_0100),
        .QDEPTH   (2)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .pc_i          (pc),
        .pc_next_o     (pc_next),
        .redirect_i    (redir),
        .redirect_pc_i (redir_pc),
        .bus           (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1; pc = 32'h55; redir = 1'b0; redir_pc = 32'h0;
        bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0;
        bus.imem_rdata = 32'h0; bus.inst_ready = 1'b0;
        tick(); tick();
        settle();
        chk("rst_req", {31'b0, bus.imem_req}, 32'd0);
        chk("rst_valid", {31'b0, bus.inst_valid}, 32'd0);
        chk("rst_pcnext", pc_next, 32'h100);
        chk("rst_inst", bus.inst, 32'h0);
        chk("rst_instpc", bus.inst_pc, 32'h0);

        // first fetch, latency
        rst = 1'b0; pc = 32'h0; bus.imem_gnt = 1'b1; bus.inst_ready = 1'b1;
        settle();
        chk("f0_req", {31'b0, bus.imem_req}, 32'd1);
        chk("f0_addr", bus.imem_addr, 32'h0);
        chk("f0_pcnext", pc_next, 32'h4);
        tick();
        bus.imem_gnt = 1'b0; pc = 32'h4;
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h2002_0005;
        settle();
        chk("f0_wait_req", {31'b0, bus.imem_req}, 32'd0);
        chk("f0_wait_pcn", pc_next, 32'h4);
        chk("f0_wait_val", {31'b0, bus.inst_valid}, 32'd0);
        tick();
        bus.imem_rvalid = 1'b0;
        settle();
        chk("f0_valid", {31'b0, bus.inst_valid}, 32'd1);
        chk("f0_inst", bus.inst, 32'h2002_0005);
        chk("f0_instpc", bus.inst_pc, 32'h0);
        tick();
        chk("f0_popped", {31'b0, bus.inst_valid}, 32'd0);

        // ungranted stall holds the address
        bus.inst_ready = 1'b0; pc = 32'h10;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("stall_req", {31'b0, bus.imem_req}, 32'd1);
            chk("stall_addr", bus.imem_addr, 32'h10);
            chk("stall_pcn", pc_next, 32'h10);
            tick();
        end
        bus.imem_gnt = 1'b1;
        settle();
        chk("stall_gnt_pcn", pc_next, 32'h14);
        tick();

        // fill queue with ready low
        bus.imem_gnt = 1'b0; pc = 32'h14;
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hA1;
        tick();
        bus.imem_rvalid = 1'b0; bus.imem_gnt = 1'b1;
        settle();
        chk("fill_req1", {31'b0, bus.imem_req}, 32'd1);
        tick();
        bus.imem_gnt = 1'b0; pc = 32'h18;
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hA2;
        tick();
        bus.imem_rvalid = 1'b0; bus.imem_gnt = 1'b1;
        settle();
        chk("full_req", {31'b0, bus.imem_req}, 32'd0);
        chk("full_pcn", pc_next, 32'h18);
        chk("full_head", bus.inst, 32'hA1);
        chk("full_headpc", bus.inst_pc, 32'h10);
        bus.inst_ready = 1'b1;
        tick();
        bus.inst_ready = 1'b0;
        settle();
        chk("reissue_req", {31'b0, bus.imem_req}, 32'd1);
        chk("pop_head", bus.inst, 32'hA2);
        chk("pop_headpc", bus.inst_pc, 32'h14);
        tick();

        // simultaneous push and pop
        bus.imem_gnt = 1'b0; pc = 32'h1C;
        bus.inst_ready = 1'b1; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hA3;
        tick();
        bus.inst_ready = 1'b0; bus.imem_rvalid = 1'b0;
        settle();
        chk("pp_valid", {31'b0, bus.inst_valid}, 32'd1);
        chk("pp_head", bus.inst, 32'hA3);
        chk("pp_headpc", bus.inst_pc, 32'h18);

        // response while idle is ignored
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hDEAD;
        tick();
        bus.imem_rvalid = 1'b0; bus.inst_ready = 1'b1;
        tick();
        bus.inst_ready = 1'b0;
        settle();
        chk("idle_rv_ign", {31'b0, bus.inst_valid}, 32'd0);

        // put one entry back, then redirect during WAIT
        bus.imem_gnt = 1'b1;
        tick();
        bus.imem_gnt = 1'b0; pc = 32'h20;
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hA4;
        tick();
        bus.imem_rvalid = 1'b0; bus.imem_gnt = 1'b1;
        tick();
        bus.imem_gnt = 1'b0; redir = 1'b1; redir_pc = 32'h40;
        settle();
        chk("rd_pcn", pc_next, 32'h40);
        chk("rd_req", {31'b0, bus.imem_req}, 32'd0);
        tick();
        redir = 1'b0; pc = 32'h40;
        settle();
        chk("rd_flush", {31'b0, bus.inst_valid}, 32'd0);
        chk("drop_req", {31'b0, bus.imem_req}, 32'd0);
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hBAD0;
        tick();
        bus.imem_rvalid = 1'b0;
        settle();
        chk("drop_disc", {31'b0, bus.inst_valid}, 32'd0);
        chk("drop_req2", {31'b0, bus.imem_req}, 32'd1);
        chk("drop_addr", bus.imem_addr, 32'h40);

        // redirect and response in the same cycle
        bus.imem_gnt = 1'b1;
        tick();
        bus.imem_gnt = 1'b0; redir = 1'b1; redir_pc = 32'h80;
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hBAD1;
        tick();
        redir = 1'b0; bus.imem_rvalid = 1'b0; pc = 32'h80;
        settle();
        chk("rr_valid", {31'b0, bus.inst_valid}, 32'd0);
        chk("rr_idle_req", {31'b0, bus.imem_req}, 32'd1);

        // PC wrap, then reset mid-WAIT
        pc = 32'hFFFF_FFFC; bus.imem_gnt = 1'b1;
        settle();
        chk("wrap_pcn", pc_next, 32'h0);
        tick();
        bus.imem_gnt = 1'b0; rst = 1'b1;
        settle();
        chk("mid_rst_pcn", pc_next, 32'h100);
        chk("mid_rst_req", {31'b0, bus.imem_req}, 32'd0);
        tick();
        rst = 1'b0; pc = 32'h0;
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hBAD2;
        tick();
        bus.imem_rvalid = 1'b0;
        settle();
        chk("late_rv_ign", {31'b0, bus.inst_valid}, 32'd0);
        chk("late_req", {31'b0, bus.imem_req}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, value driven on pc_next_o while in reset.
REQ-003 Parameter QDEPTH, default 2, instruction queue depth (2..8).
REQ-004 clk_i  in  1  clock, all state updates on rising edge.
REQ-005 rst_i  in  1  synchronous active-high reset.
REQ-006 pc_i  in  32  current PC from the program-counter register.
REQ-007 pc_next_o  out  32  next PC, loaded by the program-counter register every cycle.
REQ-008 redirect_i / redirect_pc_i  in  1 / 32  taken branch/jump and its target.
REQ-009 imem_req_o / imem_addr_o  out  1 / 32  fetch request and word address.
REQ-010 imem_gnt_i  in  1  request accepted this cycle.
REQ-011 imem_rvalid_i / imem_rdata_i  in  1 / 32  response strobe and instruction word.
REQ-012 inst_valid_o / inst_o / inst_pc_o  out  1 / 32 / 32  queue head to decode.
REQ-013 inst_ready_i  in  1  decode accepts queue head.

Function
REQ-014 FSM states SHALL be IDLE, WAIT (one request granted, response pending) and DROP (pending response to be discarded); at most one request outstanding.
REQ-015 imem_req_o SHALL be 1 iff state==IDLE, !rst_i, !redirect_i and (count + 0) < QDEPTH; imem_addr_o SHALL equal {pc_i[31:2],2'b00}.
REQ-016 pc_next_o priority: rst_i -> RESET_PC; redirect_i -> redirect_pc_i; imem_req_o&&imem_gnt_i -> pc_i+4 (mod 2^32); else pc_i (stall, holds address stable while ungranted).
REQ-017 IDLE->WAIT on imem_req_o&&imem_gnt_i, capturing pc_i as pending_pc.
REQ-018 WAIT, imem_rvalid_i, !redirect_i: push {pending_pc, imem_rdata_i} into queue, go IDLE; earliest response is the cycle after grant (fetch-to-queue latency >= 2 cycles).
REQ-019 WAIT, redirect_i, !imem_rvalid_i: go DROP; WAIT, redirect_i and imem_rvalid_i same cycle: discard data, go IDLE.
REQ-020 DROP: on imem_rvalid_i discard data, go IDLE; redirect_i in DROP SHALL keep state DROP.
REQ-021 imem_rvalid_i in IDLE SHALL be ignored.
REQ-022 Queue SHALL be FIFO; pop when inst_valid_o&&inst_ready_i; inst_valid_o = (count!=0); inst_o/inst_pc_o show head entry.
REQ-023 Request gating SHALL count the outstanding request: request only if count + (state!=IDLE) < QDEPTH, so push never occurs when full.
REQ-024 Simultaneous push and pop SHALL leave count unchanged and preserve order; pop on empty SHALL be a no-op.
REQ-025 redirect_i SHALL flush the queue (count=0, inst_valid_o=0 next cycle) and override any same-cycle push or pop.
REQ-026 PC wrap: pc_i=32'hFFFF_FFFC with grant SHALL give pc_next_o=32'h0000_0000.

Reset
REQ-027 rst_i high at a rising edge SHALL set state IDLE, count 0, queue pointers 0, pending_pc 0.
REQ-028 While rst_i high: imem_req_o=0, inst_valid_o=0, pc_next_o=RESET_PC; inst_o and inst_pc_o SHALL read 0.
REQ-029 Reset mid-operation (WAIT/DROP) SHALL abandon the outstanding request; its later response arrives in IDLE and is ignored per REQ-021.

Verification
REQ-030 Reset then pc_i=0, gnt=1, rvalid next cycle with 32'h2002_0005, ready=1 -> pc_next_o=4 in grant cycle; inst_valid_o=1, inst_o=32'h2002_0005, inst_pc_o=0 one cycle after rvalid.
REQ-031 gnt held 0 for 3 cycles at pc_i=32'h10 -> imem_req_o=1, imem_addr_o=32'h10, pc_next_o=32'h10 each cycle; on grant pc_next_o=32'h14.
REQ-032 ready=0, QDEPTH=2, two fetches complete -> count=2, imem_req_o=0; one pop -> request reissued next cycle.
REQ-033 redirect_i with redirect_pc_i=32'h40 while WAIT -> pc_next_o=32'h40, queue empty next cycle, state DROP; following rvalid discarded, next fetch at 32'h40.
REQ-034 redirect_i and imem_rvalid_i same cycle -> no push, state IDLE, inst_valid_o=0.
REQ-035 pc_i=32'hFFFF_FFFC granted -> pc_next_o=0; rst_i pulsed during WAIT -> inst_valid_o=0, late rvalid ignored.
